// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : pipeline <-> hazard unit signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D, RA2D, RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW;
  logic             MemtoRegE, BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemTimeout, StallCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemTimeout, StallCount
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : forwarding, load-use/branch hazards and memory-wait stalls
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int               WCNT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] C_WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [3:0]        C_PC_REG   = 4'd15;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       mem_stall, mem_timeout, ld_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  // Memory stage wins over writeback; R15 (PC) is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       we_m,
    input logic [3:0] wa_w,
    input logic       we_w
  );
    if (we_m && (wa_m == ra) && (wa_m != C_PC_REG))
      return 2'b10;
    else if (we_w && (wa_w == ra) && (wa_w != C_PC_REG))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_stall   = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_d   = MEM_WAIT;
          wcnt_d    = WCNT_W'(1);
          mem_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == C_WCNT_MAX) begin
          state_d     = RUN;
          wcnt_d      = '0;
          mem_timeout = 1'b1;
        end else begin
          wcnt_d    = wcnt_q + WCNT_W'(1);
          mem_stall = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    ld_stall = hz.MemtoRegE && (hz.WA3E != C_PC_REG) &&
               ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.RA1E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
      fwd_b = fwd_sel(hz.RA2E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
      // A held branch flushes only once the memory wait releases the pipeline.
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.BranchTakenE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (ld_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.MemTimeout = mem_timeout && !reset;
  assign hz.StallCount = reset ? '0 : stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : vector table, directed corner sequences and random stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif();
  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: cycles already spent on the current memory access
  // (0 = not waiting) and the number of stalled cycles seen so far.
  int waited = 0;
  int cnt_m  = 0;
  logic [11:0] last_exp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (hif.RegWriteM && hif.WA3M == ra) return 2'b10;
    if (hif.RegWriteW && hif.WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // {fa, fb, sf, sd, se, sm, fd, fe, fw, timeout}
  function automatic logic [11:0] ref_out();
    bit ld, ms, to;
    logic [11:0] r;
    if (reset) return 12'b0000_0000_1110;
    ld = hif.MemtoRegE && hif.WA3E != 4'd15 && (hif.WA3E == hif.RA1D || hif.WA3E == hif.RA2D);
    if (waited == 0) begin
      ms = hif.MemReqM && !hif.MemReadyM;
      to = 1'b0;
    end else begin
      ms = !hif.MemReadyM && waited < MEM_TIMEOUT;
      to = !hif.MemReadyM && waited == MEM_TIMEOUT;
    end
    r = '0;
    r[11:10] = ref_fwd(hif.RA1E);
    r[9:8]   = ref_fwd(hif.RA2E);
    r[0]     = to;
    if (ms)                    r[7:1] = 7'b1111_001;
    else if (hif.BranchTakenE) r[7:1] = 7'b0000_110;
    else if (ld)               r[7:1] = 7'b1100_010;
    return r;
  endfunction

  function automatic logic [11:0] dut_out();
    return {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE, hif.StallM,
            hif.FlushD, hif.FlushE, hif.FlushW, hif.MemTimeout};
  endfunction

  task automatic sample();
    @(negedge clk);
    last_exp = ref_out();
    check("model_outputs", {20'd0, dut_out()}, {20'd0, last_exp});
    check("model_stall_count", {24'd0, hif.StallCount}, reset ? 32'd0 : cnt_m);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      waited = 0;
      cnt_m  = 0;
    end else begin
      if (last_exp[7] && cnt_m < CMAX) cnt_m++;
      if (waited == 0)
        waited = (hif.MemReqM && !hif.MemReadyM) ? 1 : 0;
      else if (hif.MemReadyM || waited == MEM_TIMEOUT)
        waited = 0;
      else
        waited++;
    end
    #1;
  endtask

  task automatic set_idle();
    hif.RA1D = 0; hif.RA2D = 0; hif.RA1E = 0; hif.RA2E = 0;
    hif.WA3E = 0; hif.WA3M = 0; hif.WA3W = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.MemtoRegE = 0;
    hif.BranchTakenE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    case ($urandom_range(0, 3))
      0:       return 4'd3;
      1:       return 4'd5;
      2:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwm, rww, m2r, br;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 0, 3, 0, 0, 3, 3, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 3, 0, 0, 3, 3, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 15, 0, 0, 15, 15, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 7, 0, 7, 7, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 9, 9, 0, 9, 9, 1, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0};
    vecs[5]  = '{0, 5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1};
    vecs[6]  = '{15, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[7]  = '{5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 4, 6, 0, 4, 6, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0};
    vecs[11] = '{2, 2, 0, 0, 2, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1};

    // Reset with hazards present on the inputs: everything must be masked.
    reset = 1'b1;
    set_idle();
    hif.RegWriteM = 1; hif.WA3M = 3; hif.RA1E = 3; hif.MemReqM = 1;
    sample();
    check("reset_outputs", {20'd0, dut_out()}, 32'h00E);
    check("reset_count", {24'd0, hif.StallCount}, 0);
    advance();
    sample();
    advance();
    reset = 1'b0;
    set_idle();

    // Load-use stall counted once.
    hif.MemtoRegE = 1; hif.WA3E = 5; hif.RA2D = 5;
    sample();
    check("lduse_stall", {29'd0, hif.StallF, hif.StallD, hif.FlushE}, 3'b111);
    check("lduse_count_before", {24'd0, hif.StallCount}, 0);
    advance();
    set_idle();
    sample();
    check("lduse_count_after", {24'd0, hif.StallCount}, 1);
    advance();

    foreach (vecs[i]) begin
      hif.RA1D = vecs[i].ra1d; hif.RA2D = vecs[i].ra2d;
      hif.RA1E = vecs[i].ra1e; hif.RA2E = vecs[i].ra2e;
      hif.WA3E = vecs[i].wa3e; hif.WA3M = vecs[i].wa3m; hif.WA3W = vecs[i].wa3w;
      hif.RegWriteM = vecs[i].rwm; hif.RegWriteW = vecs[i].rww;
      hif.MemtoRegE = vecs[i].m2r; hif.BranchTakenE = vecs[i].br;
      hif.MemReqM = 0; hif.MemReadyM = 0;
      sample();
      check($sformatf("vec%0d", i),
            {24'd0, hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.FlushD, hif.FlushE},
            {24'd0, vecs[i].fa, vecs[i].fb, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe});
      advance();
    end
    set_idle();

    // Three-cycle memory wait, then release.
    hif.MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("memwait_stall", {25'd0, hif.StallF, hif.StallD, hif.StallE, hif.StallM,
            hif.FlushW, hif.FlushD, hif.FlushE}, 7'b11111_00);
      advance();
    end
    hif.MemReadyM = 1;
    sample();
    check("memwait_release", {25'd0, hif.StallF, hif.StallD, hif.StallE, hif.StallM,
          hif.FlushW, hif.FlushD, hif.FlushE}, 0);
    advance();
    set_idle();
    sample();
    check("memwait_back_to_run", {31'd0, hif.StallF}, 0);
    advance();

    // Timeout pulses once, in the 16th wait cycle, with stalls dropped.
    begin
      int to_cycle = 0;
      int to_count = 0;
      hif.MemReqM = 1;
      for (int i = 1; i <= MEM_TIMEOUT + 1; i++) begin
        sample();
        if (hif.MemTimeout === 1'b1) begin
          to_count++;
          if (to_cycle == 0) to_cycle = i;
          check("timeout_stall_drop", {31'd0, hif.StallF}, 0);
        end
        advance();
      end
      check("timeout_cycle", to_cycle, MEM_TIMEOUT + 1);
      check("timeout_pulses", to_count, 1);
    end
    set_idle();
    sample();
    advance();

    // Branch held through a wait flushes only in the release cycle.
    hif.MemReqM = 1; hif.BranchTakenE = 1;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("branch_held_no_flush", {30'd0, hif.FlushD, hif.FlushE}, 0);
      advance();
    end
    hif.MemReadyM = 1; hif.MemtoRegE = 1; hif.WA3E = 5; hif.RA1D = 5;
    sample();
    check("branch_release", {28'd0, hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}, 4'b0011);
    advance();
    set_idle();
    sample();
    check("branch_after_release", {30'd0, hif.FlushD, hif.FlushE}, 0);
    advance();

    // Reset in the 2nd wait cycle aborts silently.
    hif.MemReqM = 1;
    sample();
    advance();
    reset = 1'b1;
    sample();
    check("reset_wait_no_timeout", {31'd0, hif.MemTimeout}, 0);
    advance();
    reset = 1'b0;
    hif.MemReqM = 0;
    sample();
    check("reset_wait_is_run", {31'd0, hif.StallF}, 0);
    check("reset_wait_count", {24'd0, hif.StallCount}, 0);
    check("reset_wait_timeout", {31'd0, hif.MemTimeout}, 0);
    advance();

    // Long unanswered request drives the stall counter into saturation.
    hif.MemReqM = 1;
    for (int i = 0; i < 300; i++) begin
      sample();
      advance();
    end
    sample();
    check("stall_count_saturated", {24'd0, hif.StallCount}, CMAX);
    advance();
    set_idle();

    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (i < 1500) ? 40 : 4;
      reset = ($urandom_range(0, 63) == 0);
      hif.RA1D = rnd_reg(); hif.RA2D = rnd_reg();
      hif.RA1E = rnd_reg(); hif.RA2E = rnd_reg();
      hif.WA3E = rnd_reg(); hif.WA3M = rnd_reg(); hif.WA3W = rnd_reg();
      hif.RegWriteM    = 1'($urandom_range(0, 1));
      hif.RegWriteW    = 1'($urandom_range(0, 1));
      hif.MemtoRegE    = 1'($urandom_range(0, 1));
      hif.BranchTakenE = ($urandom_range(0, 3) == 0);
      hif.MemReqM      = 1'($urandom_range(0, 1));
      hif.MemReadyM    = ($urandom_range(0, 99) < rdy_pct);
      sample();
      advance();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum memory-wait cycles before abort.
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RA1D, RA2D  input  4 each  source register addresses in Decode.
REQ-006 RA1E, RA2E  input  4 each  source register addresses in Execute.
REQ-007 WA3E, WA3M, WA3W  input  4 each  destination register in Execute/Memory/Writeback.
REQ-008 RegWriteM, RegWriteW  input  1 each  destination write enable in Memory/Writeback.
REQ-009 MemtoRegE  input  1  instruction in Execute is a load.
REQ-010 BranchTakenE  input  1  taken branch or PC write resolved in Execute.
REQ-011 MemReqM  input  1  instruction in Memory accesses data memory.
REQ-012 MemReadyM  input  1  data memory completes the access this cycle.
REQ-013 ForwardAE, ForwardBE  output  2 each  00 regfile, 01 ResultW, 10 ALUOutM.
REQ-014 StallF, StallD, StallE, StallM  output  1 each  hold the pipeline register of that stage.
REQ-015 FlushD, FlushE, FlushW  output  1 each  load a bubble into that stage register.
REQ-016 MemTimeout  output  1  one-cycle pulse when a memory wait is aborted.
REQ-017 StallCount  output  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-018 Forwarding is combinational: ForwardAE=10 if RegWriteM and WA3M==RA1E and WA3M!=15; else 01 if RegWriteW and WA3W==RA1E and WA3W!=15; else 00. ForwardBE is the same using RA2E.
REQ-019 Memory stage has priority over Writeback when both match; R15 is never forwarded.
REQ-020 Load-use: LdStall = MemtoRegE and WA3E!=15 and (WA3E==RA1D or WA3E==RA2D).
REQ-021 FSM states RUN and MEM_WAIT, plus a wait counter wcnt of width ceil(log2(MEM_TIMEOUT+1)).
REQ-022 RUN -> MEM_WAIT when MemReqM=1 and MemReadyM=0; wcnt loads 1.
REQ-023 MEM_WAIT -> RUN when MemReadyM=1; wcnt clears.
REQ-024 MEM_WAIT with MemReadyM=0 and wcnt==MEM_TIMEOUT -> RUN, MemTimeout=1 for that cycle, wcnt clears; otherwise wcnt increments.
REQ-025 MemStall = (state==RUN and MemReqM and !MemReadyM) or (state==MEM_WAIT and !MemReadyM and wcnt!=MEM_TIMEOUT).
REQ-026 MemStall=1: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0, FlushW=1; it overrides load-use and branch.
REQ-027 BranchTakenE is held while E is stalled; its flush takes effect in the first cycle in which MemStall=0.
REQ-028 MemStall=0 and BranchTakenE=1: FlushD=FlushE=1, StallF=StallD=0; branch overrides LdStall.
REQ-029 MemStall=0, BranchTakenE=0, LdStall=1: StallF=StallD=1, FlushE=1, FlushD=0.
REQ-030 No condition active: all stalls and flushes are 0.
REQ-031 StallCount increments each cycle StallF=1 and saturates at all-ones.
REQ-032 Data hazard zero latency: all stall, flush and forward outputs are combinational in current inputs and state.

Reset
REQ-033 While reset=1: state=RUN, wcnt=0, StallCount=0, MemTimeout=0, all stalls 0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00.
REQ-034 Reset asserted in MEM_WAIT aborts the wait without a MemTimeout pulse; the first cycle after reset is RUN.

Verification
REQ-035 RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10; with RegWriteM=0 -> 01; with WA3M=WA3W=15, RA1E=15 -> 00.
REQ-036 MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, StallCount 0->1.
REQ-037 MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls and FlushW =1 for 3 cycles, then 0; state returns to RUN.
REQ-038 MEM_TIMEOUT=15, MemReadyM held 0 -> MemTimeout pulses once, in the 16th cycle of the wait; stalls drop that cycle.
REQ-039 BranchTakenE=1 during MEM_WAIT, then MemReadyM=1 -> FlushD=FlushE=1 only in the release cycle; with LdStall also =1 -> StallF=0.
REQ-040 Reset asserted in the 2nd wait cycle -> next cycle RUN, StallCount=0, MemTimeout never asserted.
